// File: rtl/mux_scan_pkg.sv
// Shared constants for the scanning channel multiplexer: mode encodings
// and the two-state select FSM.
package mux_scan_pkg;

  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  typedef enum logic {
    S_MAN  = 1'b0,
    S_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/mux_scan_nto1_rr_next_sel.sv
// Round-robin successor search: the first channel with mask=1 strictly after
// cur, wrapping modulo N_CH. Returns cur itself when it is the only one enabled.
module rr_next_sel #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [SEL_W-1:0] cur,
  input  logic [N_CH-1:0]  mask,
  output logic [SEL_W-1:0] nxt,
  output logic             any
);

  logic [SEL_W:0]       step;
  logic [2*N_CH-1:0]    dbl;
  logic [2*N_CH-1:0]    shifted;
  logic [N_CH-1:0]      rot;
  logic [SEL_W-1:0]     idx;

  // Rotating by cur+1 puts the candidate search order at bit 0 upward,
  // so the lowest set bit of rot is the offset to the next enabled channel.
  always_comb begin
    step    = {1'b0, cur} + (SEL_W + 1)'(1);
    dbl     = {mask, mask};
    shifted = dbl >> step;
    rot     = shifted[N_CH-1:0];
    idx     = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) idx = SEL_W'(i);
    end
    nxt = cur + SEL_W'(1) + idx;
    any = |mask;
  end

endmodule

// File: rtl/mux_scan_nto1.sv
// Registered N-to-1 channel multiplexer with a manual (loadable select) mode
// and an auto-scan mode that walks enabled channels with a fixed dwell time.
module mux_scan_nto1
  import mux_scan_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 1,
  parameter int DWELL = 1,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  sel_ld,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic [N_CH-1:0]       en_mask,
  input  logic [N_CH*WIDTH-1:0] d,
  output logic [WIDTH-1:0]      o,
  output logic                  o_valid,
  output logic [SEL_W-1:0]      cur_sel
);

  localparam int              DW_W       = $clog2(DWELL + 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  state_t            state;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  sel_d;
  logic [DW_W-1:0]   dwell_q;
  logic [DW_W-1:0]   dwell_d;
  logic [DW_W-1:0]   dwell_base;
  logic [SEL_W-1:0]  nxt_sel;
  logic              any_en;
  logic [WIDTH-1:0]  ch [N_CH];

  rr_next_sel #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_next (
    .cur  (sel_q),
    .mask (en_mask),
    .nxt  (nxt_sel),
    .any  (any_en)
  );

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      ch[i] = d[i*WIDTH +: WIDTH];
    end
  end

  // The mode input of the current cycle governs the select update, so a
  // sel_ld arriving together with a scan-to-manual switch is honoured.
  // Entering scan restarts the dwell; a disabled current channel is left
  // immediately rather than after its dwell expires.
  always_comb begin
    sel_d      = sel_q;
    dwell_d    = dwell_q;
    dwell_base = (state == S_MAN) ? '0 : dwell_q;
    if (mode == MODE_MAN) begin
      dwell_d = '0;
      if (sel_ld) sel_d = sel_in;
    end else if (!any_en) begin
      sel_d   = sel_q;
      dwell_d = dwell_q;
    end else if (!en_mask[sel_q] || dwell_base == DWELL_LAST) begin
      sel_d   = nxt_sel;
      dwell_d = '0;
    end else begin
      dwell_d = dwell_base + DW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_MAN;
      sel_q   <= '0;
      dwell_q <= '0;
      o       <= '0;
      o_valid <= 1'b0;
      cur_sel <= '0;
    end else begin
      state   <= (mode == MODE_SCAN) ? S_SCAN : S_MAN;
      sel_q   <= sel_d;
      dwell_q <= dwell_d;
      o       <= ch[sel_q];
      cur_sel <= sel_q;
      o_valid <= (mode == MODE_MAN) ? 1'b1 : en_mask[sel_q];
    end
  end

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Bench for mux_scan_nto1 (4 channels x 8 bits, dwell 3): directed scenarios
// with literal expectations, then randomized traffic against a queue model.
module tb_mux_scan_nto1;

  localparam int N_CH  = 4;
  localparam int WIDTH = 8;
  localparam int DWELL = 3;
  localparam int SEL_W = 2;
  localparam int W     = 1 + SEL_W + WIDTH;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  mode = 1'b0;
  logic                  sel_ld = 1'b0;
  logic [SEL_W-1:0]      sel_in = '0;
  logic [N_CH-1:0]       en_mask = '0;
  logic [N_CH*WIDTH-1:0] d = '0;
  logic [WIDTH-1:0]      o;
  logic                  o_valid;
  logic [SEL_W-1:0]      cur_sel;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_q[$];

  mux_scan_nto1 #(
    .N_CH  (N_CH),
    .WIDTH (WIDTH),
    .DWELL (DWELL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .sel_ld  (sel_ld),
    .sel_in  (sel_in),
    .en_mask (en_mask),
    .d       (d),
    .o       (o),
    .o_valid (o_valid),
    .cur_sel (cur_sel)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural model: which channel is selected and how many cycles it has
  // already been shown in scan mode
  int m_sel = 0;
  int m_cnt = 0;

  function automatic int next_enabled(int s, logic [N_CH-1:0] m);
    for (int k = 1; k <= N_CH; k++) begin
      if (m[(s + k) % N_CH]) return (s + k) % N_CH;
    end
    return s;
  endfunction

  always @(posedge clk) begin
    logic [WIDTH-1:0] chan;
    logic             v;
    if (rst) begin
      m_sel = 0;
      m_cnt = 0;
      exp_q.push_back('0);
    end else begin
      chan = d[m_sel*WIDTH +: WIDTH];
      v    = mode ? en_mask[m_sel] : 1'b1;
      exp_q.push_back({v, SEL_W'(m_sel), chan});
      if (!mode) begin
        m_cnt = 0;
        if (sel_ld) m_sel = int'(sel_in);
      end else if (en_mask == '0) begin
        m_sel = m_sel;
      end else if (!en_mask[m_sel]) begin
        m_sel = next_enabled(m_sel, en_mask);
        m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
        if (m_cnt == DWELL) begin
          m_cnt = 0;
          m_sel = next_enabled(m_sel, en_mask);
        end
      end
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests++;
      if ({o_valid, cur_sel, o} !== e) begin
        fails++;
        $display("FAIL model t=%0t: got valid=%0b sel=%0d o=%02h expected valid=%0b sel=%0d o=%02h",
                 $time, o_valid, cur_sel, o, e[W-1], e[W-2 -: SEL_W], e[WIDTH-1:0]);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  int seq [10] = '{0, 0, 0, 1, 1, 1, 3, 3, 3, 0};
  logic [SEL_W-1:0] frozen;

  initial begin
    ticks(2);
    chk("reset_o", 32'(o), 32'h0);
    chk("reset_valid", 32'(o_valid), 32'h0);
    chk("reset_sel", 32'(cur_sel), 32'h0);

    // manual load
    rst = 1'b0;
    d = 32'h44332211;
    sel_ld = 1'b1;
    sel_in = 2'd2;
    tick();
    chk("first_valid", {23'h0, o_valid, cur_sel, o}, {23'h0, 1'b1, 2'd0, 8'h11});
    sel_ld = 1'b0;
    tick();
    chk("load_o", 32'(o), 32'h33);
    chk("load_sel", 32'(cur_sel), 32'd2);
    tick();
    chk("load_hold", 32'(cur_sel), 32'd2);

    // scan with mask 1011
    sel_ld = 1'b1;
    sel_in = 2'd0;
    tick();
    sel_ld = 1'b0;
    mode = 1'b1;
    en_mask = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("scan_seq%0d", i), {29'h0, o_valid, cur_sel}, {29'h0, 1'b1, 2'(seq[i])});
    end

    // sitting on channel 1 with one dwell cycle spent, channel 1 disabled
    ticks(3);
    chk("skip_pre", 32'(cur_sel), 32'd1);
    en_mask = 4'b1001;
    tick();
    chk("skip_gap_valid", 32'(o_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("skip_dwell%0d", i), {29'h0, o_valid, cur_sel}, {29'h0, 1'b1, 2'd3});
    end
    tick();
    chk("skip_wrap", 32'(cur_sel), 32'd0);

    // empty mask freezes selection
    en_mask = 4'b0000;
    tick();
    frozen = cur_sel;
    chk("empty_valid", 32'(o_valid), 32'h0);
    ticks(2);
    chk("empty_valid2", 32'(o_valid), 32'h0);
    chk("empty_frozen", 32'(cur_sel), 32'(frozen));
    en_mask = 4'b0100;
    ticks(2);
    chk("restore", {29'h0, o_valid, cur_sel}, {29'h0, 1'b1, 2'd2});

    // mode race: switch to manual with a load in the same cycle
    en_mask = 4'b1111;
    ticks(2);
    mode = 1'b0;
    sel_ld = 1'b1;
    sel_in = 2'd1;
    tick();
    sel_ld = 1'b0;
    tick();
    chk("race_o", {21'h0, o_valid, cur_sel, o}, {21'h0, 1'b1, 2'd1, 8'h22});

    // sel_ld during scan is ignored
    mode = 1'b1;
    sel_ld = 1'b1;
    sel_in = 2'd3;
    ticks(2);
    chk("scan_ignores_ld", 32'(cur_sel), 32'd1);
    sel_ld = 1'b0;

    // reset mid-scan
    ticks(2);
    rst = 1'b1;
    tick();
    chk("midscan_reset", {21'h0, o_valid, cur_sel, o}, 32'h0);
    rst = 1'b0;
    mode = 1'b0;
    tick();
    chk("after_reset_manual", {21'h0, o_valid, cur_sel, o}, {21'h0, 1'b1, 2'd0, 8'h11});

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 1500; i++) begin
      d = {$urandom(), $urandom()};
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) en_mask = ($urandom_range(0, 5) == 0) ? 4'b0000 : N_CH'($urandom());
      sel_ld = ($urandom_range(0, 3) == 0);
      sel_in = SEL_W'($urandom());
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    ticks(2);
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
